// File: rtl/lts_averager.sv
// lts_averager
// Averages the two back-to-back long training symbols sample-by-sample and
// streams out one N_SAMP-sample averaged symbol for channel estimation.
//
// state     | meaning
// ----------+----------------------------------------------------------------
// ST_FIRST  | capturing first LTS symbol into the buffer
// ST_SECOND | averaging second LTS symbol into the buffer in place
// ST_OUTPUT | streaming the averaged symbol downstream, input stalled
// ST_DRAIN  | misframed packet (no tlast at 2*N_SAMP), discarding until tlast
module lts_averager #(
    parameter int N_SAMP = 64
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        lts_axis_tvalid,
    input  logic        lts_axis_tlast,
    input  logic [31:0] lts_axis_tdata,
    output logic        lts_axis_tready,
    output logic        avg_axis_tvalid,
    output logic        avg_axis_tlast,
    output logic [31:0] avg_axis_tdata,
    input  logic        avg_axis_tready,
    output logic        frame_err_out
);

    localparam int IDX_W = $clog2(N_SAMP);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SAMP - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {
        ST_FIRST  = 2'd0,
        ST_SECOND = 2'd1,
        ST_OUTPUT = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_next;
    logic [31:0]      buf_mem [N_SAMP];

    logic        in_xfer;
    logic        out_xfer;
    logic        at_last;
    logic [31:0] buf_rd;
    logic [31:0] avg_word;
    logic        buf_we;
    logic [31:0] buf_wdata;

    // floor((a+b)/2) without the 17-bit intermediate: halve each operand
    // arithmetically and add back the carry lost when both LSBs are set.
    function automatic logic [15:0] avg16(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] a_h;
        logic [15:0] b_h;
        a_h = {a[15], a[15:1]};
        b_h = {b[15], b[15:1]};
        return a_h + b_h + {15'd0, a[0] & b[0]};
    endfunction

    assign in_xfer  = lts_axis_tvalid && lts_axis_tready;
    assign out_xfer = avg_axis_tvalid && avg_axis_tready;
    assign at_last  = (idx == IDX_LAST);
    assign idx_next = idx + IDX_ONE;
    assign buf_rd   = buf_mem[idx];
    assign avg_word = {avg16(buf_rd[31:16], lts_axis_tdata[31:16]),
                       avg16(buf_rd[15:0],  lts_axis_tdata[15:0])};

    // Buffer write select: raw sample in the first symbol, running average in the second
    always_comb begin
        buf_we    = 1'b0;
        buf_wdata = lts_axis_tdata;
        if (in_xfer) begin
            case (state)
                ST_FIRST: begin
                    buf_we = !lts_axis_tlast;
                end
                ST_SECOND: begin
                    buf_we    = 1'b1;
                    buf_wdata = avg_word;
                end
                default: begin
                    buf_we = 1'b0;
                end
            endcase
        end
    end

    // Sample buffer; contents are don't-care after reset so it carries no reset
    always_ff @(posedge clk_in) begin
        if (buf_we) begin
            buf_mem[idx] <= buf_wdata;
        end
    end

    // Packet sequencing FSM with registered stream handshakes and error pulse
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state           <= ST_FIRST;
            idx             <= '0;
            lts_axis_tready <= 1'b0;
            avg_axis_tvalid <= 1'b0;
            avg_axis_tlast  <= 1'b0;
            avg_axis_tdata  <= '0;
            frame_err_out   <= 1'b0;
        end else begin
            frame_err_out <= 1'b0;
            case (state)
                ST_FIRST: begin
                    lts_axis_tready <= 1'b1;
                    if (in_xfer) begin
                        if (lts_axis_tlast) begin
                            frame_err_out <= 1'b1;
                            idx           <= '0;
                        end else if (at_last) begin
                            idx   <= '0;
                            state <= ST_SECOND;
                        end else begin
                            idx <= idx_next;
                        end
                    end
                end

                ST_SECOND: begin
                    lts_axis_tready <= 1'b1;
                    if (in_xfer) begin
                        if (at_last) begin
                            idx <= '0;
                            if (lts_axis_tlast) begin
                                // buf_mem[0] already holds its final average here
                                state           <= ST_OUTPUT;
                                lts_axis_tready <= 1'b0;
                                avg_axis_tvalid <= 1'b1;
                                avg_axis_tdata  <= buf_mem[0];
                                avg_axis_tlast  <= (IDX_LAST == '0);
                            end else begin
                                frame_err_out <= 1'b1;
                                state         <= ST_DRAIN;
                            end
                        end else if (lts_axis_tlast) begin
                            frame_err_out <= 1'b1;
                            idx           <= '0;
                            state         <= ST_FIRST;
                        end else begin
                            idx <= idx_next;
                        end
                    end
                end

                ST_OUTPUT: begin
                    lts_axis_tready <= 1'b0;
                    if (out_xfer) begin
                        if (avg_axis_tlast) begin
                            avg_axis_tvalid <= 1'b0;
                            avg_axis_tlast  <= 1'b0;
                            idx             <= '0;
                            state           <= ST_FIRST;
                            lts_axis_tready <= 1'b1;
                        end else begin
                            idx            <= idx_next;
                            avg_axis_tdata <= buf_mem[idx_next];
                            avg_axis_tlast <= (idx_next == IDX_LAST);
                        end
                    end
                end

                ST_DRAIN: begin
                    lts_axis_tready <= 1'b1;
                    if (in_xfer && lts_axis_tlast) begin
                        idx   <= '0;
                        state <= ST_FIRST;
                    end
                end

                default: begin
                    state           <= ST_FIRST;
                    idx             <= '0;
                    lts_axis_tready <= 1'b0;
                    avg_axis_tvalid <= 1'b0;
                    avg_axis_tlast  <= 1'b0;
                end
            endcase
        end
    end

endmodule
